tick_generator: RTL and testbench

TICK_GENERATOR -- requirements
Module: tick_generator

---
 rtl/tick_pkg.sv | 18 +
 rtl/tick_channel.sv | 82 ++++++++
 rtl/tick_generator.sv | 43 ++++
 tb/tb_tick_generator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared definitions for the tick generator: channel mode encoding and the
// reset-time divisor.
package tick_pkg;

    // Channel operating mode
    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_ONESHOT  = 2'b11
    } mode_e;

    localparam int unsigned MODE_W        = 2;
    localparam int unsigned DEFAULT_WIDTH = 18;
    // Half of the legacy 2^18 divide, so sq completes one full cycle per 2^18 clocks
    localparam int unsigned DEFAULT_DIV   = 131072;

endpackage

// File: rtl/tick_channel.sv
// One timing channel: divisor/mode registers, wrap counter and the
// tick / square-wave / one-shot-done output flops.
//   clk, rst      : clock, synchronous active-high reset
//   en            : count enable (freezes counter, forces tick low)
//   load          : load strobe for div_val / mode_val, clears run state
//   div_val       : divisor to load
//   mode_val      : mode to load
//   tick, sq, done: registered outputs
module tick_channel #(
    parameter int unsigned WIDTH       = 18,
    parameter int unsigned DEFAULT_DIV = tick_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    input  logic [1:0]       mode_val,
    output logic             tick,
    output logic             sq,
    output logic             done
);
    import tick_pkg::*;

    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    mode_e            m_q, m_d;
    logic             tick_d, sq_d, done_d;
    logic             active_c, wrap_c;

    // Next-state: load beats wrap, wrap beats plain counting
    always_comb begin
        d_d    = d_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq;
        done_d = done;

        active_c = en && (m_q != MODE_OFF) && (d_q != '0);
        wrap_c   = active_c && (cnt_q == WIDTH'(d_q - WIDTH'(1)));

        if (load) begin
            d_d    = div_val;
            m_d    = mode_e'(mode_val);
            cnt_d  = '0;
            sq_d   = 1'b0;
            done_d = 1'b0;
        end else if (wrap_c) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq;
            // One-shot retires itself after its first period
            if (m_q == MODE_ONESHOT) begin
                done_d = 1'b1;
                m_d    = MODE_OFF;
            end
        end else if (active_c) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= WIDTH'(DEFAULT_DIV);
            m_q   <= MODE_SQUARE;
            cnt_q <= '0;
            tick  <= 1'b0;
            sq    <= 1'b0;
            done  <= 1'b0;
        end else begin
            d_q   <= d_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
            tick  <= tick_d;
            sq    <= sq_d;
            done  <= done_d;
        end
    end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick / square-wave generator. Slices the packed
// configuration buses and instantiates one tick_channel per channel.
//   clk, rst  : clock, synchronous active-high reset
//   en        : global count enable
//   div_val   : NCH*WIDTH divisors, channel i at [i*WIDTH +: WIDTH]
//   mode_val  : 2*NCH modes, channel i at [2i +: 2]
//   div_load  : per-channel load strobes
//   tick, sq, done : per-channel registered outputs
module tick_generator #(
    parameter int unsigned WIDTH       = 18,
    parameter int unsigned NCH         = 2,
    parameter int unsigned DEFAULT_DIV = tick_pkg::DEFAULT_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH*WIDTH-1:0] div_val,
    input  logic [2*NCH-1:0]     mode_val,
    input  logic [NCH-1:0]       div_load,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       sq,
    output logic [NCH-1:0]       done
);
    import tick_pkg::*;

    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        tick_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .load     (div_load[i]),
            .div_val  (div_val[i*WIDTH +: WIDTH]),
            .mode_val (mode_val[2*i +: 2]),
            .tick     (tick[i]),
            .sq       (sq[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator. Uses a reduced WIDTH/DEFAULT_DIV so
// the full-period and maximum-divisor cases fit in a short run.
module tb_tick_generator;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned NCH         = 2;
    localparam int unsigned DEFAULT_DIV = 128;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [NCH*WIDTH-1:0] div_val;
    logic [2*NCH-1:0]     mode_val;
    logic [NCH-1:0]       div_load;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       sq;
    logic [NCH-1:0]       done;

    typedef struct {
        string      name;
        int         cyc;
        logic [1:0] t;
        logic [1:0] s;
        logic [1:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    tick_generator #(
        .WIDTH       (WIDTH),
        .NCH         (NCH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .mode_val (mode_val),
        .div_load (div_load),
        .tick     (tick),
        .sq       (sq),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Expected {tick, sq} k enabled edges after a clean start with divisor d
    function automatic logic [1:0] per_exp(int k, int d);
        logic t, s;
        t = (k > 0) && ((k % d) == 0);
        s = ((k / d) % 2) == 1;
        return {t, s};
    endfunction

    // Reset wins over a simultaneous load and enable
    task automatic test_reset();
        exp_t e, g;
        for (int n = 0; n < 2; n++) begin
            rst = 1'b1; en = 1'b1; div_load = 2'b11;
            div_val = {8'd5, 8'd5}; mode_val = 4'b0101;
            e.name = "reset"; e.cyc = n; e.t = 2'b00; e.s = 2'b00; e.d = 2'b00;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
        rst = 1'b0; div_load = 2'b00;
    endtask

    // Defaults after reset: SQUARE, period DEFAULT_DIV per sq edge, both channels
    task automatic test_default();
        exp_t e, g;
        logic [1:0] p;
        en = 1'b1;
        for (int n = 1; n <= 2 * int'(DEFAULT_DIV) + 1; n++) begin
            p = per_exp(n, int'(DEFAULT_DIV));
            e.name = "default"; e.cyc = n;
            e.t = {p[1], p[1]}; e.s = {p[0], p[0]}; e.d = 2'b00;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
    endtask

    // Independent simultaneous loads: ch1 D=5, ch0 D=3, both PERIODIC
    task automatic test_periodic();
        exp_t e, g;
        logic [1:0] p0, p1;
        for (int n = 0; n <= 30; n++) begin
            div_load = (n == 0) ? 2'b11 : 2'b00;
            div_val  = {8'd5, 8'd3};
            mode_val = {2'b01, 2'b01};
            p0 = per_exp(n, 3);
            p1 = per_exp(n, 5);
            e.name = "periodic"; e.cyc = n;
            e.t = {p1[1], p0[1]}; e.s = {p1[0], p0[0]}; e.d = 2'b00;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
    endtask

    // ch0 ONESHOT D=3 with a reload 104 edges later; ch1 OFF
    task automatic test_oneshot();
        exp_t e, g;
        int k;
        for (int n = 0; n <= 108; n++) begin
            if (n == 0) div_load = 2'b11;
            else if (n == 104) div_load = 2'b01;
            else div_load = 2'b00;
            div_val  = {8'd9, 8'd3};
            mode_val = {2'b00, 2'b11};
            k = (n < 104) ? n : n - 104;
            e.name = "oneshot"; e.cyc = n;
            e.t = {1'b0, (k == 3)}; e.s = {1'b0, (k >= 3)}; e.d = {1'b0, (k >= 3)};
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
        div_load = 2'b00;
    endtask

    // en low for 10 edges at cnt=2 on ch0 (D=4); ch1 D=1 ticks every enabled edge
    task automatic test_enable();
        exp_t e, g;
        logic [1:0] p0, p1;
        logic en_n;
        int ecnt;
        for (int n = 0; n <= 20; n++) begin
            en_n     = !(n >= 3 && n <= 12);
            en       = en_n;
            div_load = (n == 0) ? 2'b11 : 2'b00;
            div_val  = {8'd1, 8'd4};
            mode_val = {2'b01, 2'b01};
            ecnt = (n <= 2) ? n : ((n <= 12) ? 2 : n - 10);
            p0 = per_exp(ecnt, 4);
            p1 = per_exp(ecnt, 1);
            e.name = "enable"; e.cyc = n;
            e.t = {p1[1] & en_n, p0[1] & en_n}; e.s = {p1[0], p0[0]}; e.d = 2'b00;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
        en = 1'b1;
    endtask

    // Reload ch0 (D=4 -> D=2) exactly on a wrap edge while sq is high
    task automatic test_load_wrap();
        exp_t e, g;
        logic [1:0] p0;
        for (int n = 0; n <= 12; n++) begin
            div_load = (n == 0) ? 2'b11 : ((n == 8) ? 2'b01 : 2'b00);
            div_val  = {8'd6, (n < 8) ? 8'd4 : 8'd2};
            mode_val = {2'b00, 2'b01};
            p0 = (n < 8) ? per_exp(n, 4) : per_exp(n - 8, 2);
            e.name = "load_wrap"; e.cyc = n;
            e.t = {1'b0, p0[1]}; e.s = {1'b0, p0[0]}; e.d = 2'b00;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
        div_load = 2'b00;
    endtask

    // ch0 D=2^WIDTH-1 PERIODIC; ch1 D=0 PERIODIC stays idle
    task automatic test_max_div();
        exp_t e, g;
        logic [1:0] p0;
        for (int n = 0; n <= 257; n++) begin
            div_load = (n == 0) ? 2'b11 : 2'b00;
            div_val  = {8'd0, 8'd255};
            mode_val = {2'b01, 2'b01};
            p0 = per_exp(n, 255);
            e.name = "max_div"; e.cyc = n;
            e.t = {1'b0, p0[1]}; e.s = {1'b0, p0[0]}; e.d = 2'b00;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
        div_load = 2'b00;
    endtask

    // Reset mid-period in PERIODIC D=7, then defaults must be back in force
    task automatic test_reset_mid();
        exp_t e, g;
        logic [1:0] p;
        for (int n = 0; n <= 141; n++) begin
            div_load = (n == 0) ? 2'b11 : 2'b00;
            div_val  = {8'd7, 8'd7};
            mode_val = {2'b01, 2'b01};
            rst      = (n == 11);
            if (n < 11) p = per_exp(n, 7);
            else if (n == 11) p = 2'b00;
            else p = per_exp(n - 11, int'(DEFAULT_DIV));
            e.name = "reset_mid"; e.cyc = n;
            e.t = {p[1], p[1]}; e.s = {p[0], p[0]}; e.d = 2'b00;
            sb.push_back(e);
            @(posedge clk); #1;
            g = sb.pop_front(); checks++;
            if ({tick, sq, done} !== {g.t, g.s, g.d}) begin
                errors++;
                $display("FAIL %s cyc=%0d got tick=%b sq=%b done=%b want tick=%b sq=%b done=%b",
                         g.name, g.cyc, tick, sq, done, g.t, g.s, g.d);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        div_load = '0;
        div_val  = '0;
        mode_val = '0;

        test_reset();
        test_default();
        test_periodic();
        test_oneshot();
        test_enable();
        test_load_wrap();
        test_max_div();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
